// File: rtl/b2d_pkg.sv
// Shared types for the binary-to-decimal indicator decoder.
// Pure declarations; no latency, no flow control.
package b2d_pkg;

    localparam int CODE_W    = 4;
    localparam int DIGIT_MAX = 9;

    typedef logic [CODE_W-1:0]  code_t;
    typedef logic [DIGIT_MAX:1] onehot_t;

    // Codes outside 1..DIGIT_MAX map to an all-clear vector.
    function automatic onehot_t digit_onehot(input code_t code);
        onehot_t oh;
        oh = '0;
        for (int k = 1; k <= DIGIT_MAX; k++) begin
            if (code == code_t'(k)) begin
                oh[k] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/b2d_sync.sv
// N-stage nibble synchronizer, latency N edges (N=0 is a wire).
// No backpressure: samples every edge, stages clear to zero on reset.
module b2d_sync
    import b2d_pkg::*;
#(
    parameter int N = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  code_t din,
    output code_t dout
);

    if (N == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst_n};
        assign dout = din;
    end else begin : g_stages
        code_t stage_d [N];
        code_t stage_q [N];

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < N; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign dout = stage_q[N-1];
    end

endmodule

// File: rtl/b2d_decoder.sv
// Registered 4-bit code to one-hot digit/zero/err decoder with change pulse.
// Latency 1+SYNC_STAGES edges; no backpressure, outputs update every edge.
module b2d_decoder
    import b2d_pkg::*;
#(
    parameter int SYNC_STAGES    = 0,
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    output logic b1,
    output logic b2,
    output logic b3,
    output logic b4,
    output logic b5,
    output logic b6,
    output logic b7,
    output logic b8,
    output logic b9,
    output logic zero,
    output logic err,
    output logic chg
);

    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("b2d_decoder: SYNC_STAGES must be in 0..3");
    end

    code_t code_in;
    code_t code_sync;

    assign code_in = {a0, a1, a2, a3};

    b2d_sync #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (code_in),
        .dout (code_sync)
    );

    code_t   code_d,  code_q;
    onehot_t b_d,     b_q;
    logic    zero_d,  zero_q;
    logic    err_d,   err_q;
    logic    chg_d,   chg_q;

    // code_q still holds the previous registered code when the next one is
    // loaded, so it doubles as prev_code and chg is registered with the decode.
    always_comb begin
        code_d = code_sync;
        b_d    = digit_onehot(code_d) ^ {DIGIT_MAX{OUT_ACTIVE_LOW}};
        zero_d = (code_d == '0) ^ OUT_ACTIVE_LOW;
        err_d  = code_d > code_t'(DIGIT_MAX);
        chg_d  = code_d != code_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            b_q    <= {DIGIT_MAX{OUT_ACTIVE_LOW}};
            zero_q <= OUT_ACTIVE_LOW;
            err_q  <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            b_q    <= b_d;
            zero_q <= zero_d;
            err_q  <= err_d;
            chg_q  <= chg_d;
        end
    end

    assign b1   = b_q[1];
    assign b2   = b_q[2];
    assign b3   = b_q[3];
    assign b4   = b_q[4];
    assign b5   = b_q[5];
    assign b6   = b_q[6];
    assign b7   = b_q[7];
    assign b8   = b_q[8];
    assign b9   = b_q[9];
    assign zero = zero_q;
    assign err  = err_q;
    assign chg  = chg_q;

endmodule

// File: tb/tb_b2d_decoder.sv
// Bench for b2d_decoder: three instances (plain, 2-stage sync, active-low)
// checked against a sampled-history model plus directed sequences.
module tb_b2d_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;

    wire [9:1] b0, b2s, bl;
    wire z0, e0, c0, z2, e2, c2, zl, el, cl;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;
    int q[$];

    always #5 clk = ~clk;

    b2d_decoder #(.SYNC_STAGES(0), .OUT_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b1(b0[1]), .b2(b0[2]), .b3(b0[3]), .b4(b0[4]), .b5(b0[5]),
        .b6(b0[6]), .b7(b0[7]), .b8(b0[8]), .b9(b0[9]),
        .zero(z0), .err(e0), .chg(c0));

    b2d_decoder #(.SYNC_STAGES(2), .OUT_ACTIVE_LOW(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b1(b2s[1]), .b2(b2s[2]), .b3(b2s[3]), .b4(b2s[4]), .b5(b2s[5]),
        .b6(b2s[6]), .b7(b2s[7]), .b8(b2s[8]), .b9(b2s[9]),
        .zero(z2), .err(e2), .chg(c2));

    b2d_decoder #(.SYNC_STAGES(0), .OUT_ACTIVE_LOW(1'b1)) dutl (
        .clk(clk), .rst_n(rst_n), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b1(bl[1]), .b2(bl[2]), .b3(bl[3]), .b4(bl[4]), .b5(bl[5]),
        .b6(bl[6]), .b7(bl[7]), .b8(bl[8]), .b9(bl[9]),
        .zero(zl), .err(el), .chg(cl));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: history of codes sampled at each edge since reset, newest first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            q.push_front(int'({a0, a1, a2, a3}));
            if (q.size() > 5) void'(q.pop_back());
        end
    end

    // Expected {b9..b1, zero, err, chg} for an instance with s sync stages.
    function automatic logic [11:0] expect_out(input int s, input bit pol);
        int cur, prev;
        logic [9:1] bv;
        logic z, e, c;
        if (q.size() == 0) return {{9{pol}}, pol, 2'b00};
        cur  = (q.size() > s)     ? q[s]   : 0;
        prev = (q.size() > s + 1) ? q[s+1] : 0;
        for (int k = 1; k <= 9; k++) bv[k] = (cur == k) ^ pol;
        z = (cur == 0) ^ pol;
        e = (cur >= 10);
        c = (cur != prev);
        return {bv, z, e, c};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_s0",  {b0, z0, e0, c0},  expect_out(0, 1'b0));
            check("model_s2",  {b2s, z2, e2, c2}, expect_out(2, 1'b0));
            check("model_pol", {bl, zl, el, cl},  expect_out(0, 1'b1));
            if (q.size() > 0) check("onehot_s0", $countones({b0, z0, e0}), 1);
        end
    end

    task automatic set_code(input logic [3:0] c);
        @(posedge clk);
        #3;
        {a0, a1, a2, a3} = c;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] code;
        logic [9:1] b;
        logic       zero;
        logic       err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        tbl[0]  = '{4'h0, 9'h000, 1'b1, 1'b0};
        tbl[1]  = '{4'h1, 9'h001, 1'b0, 1'b0};
        tbl[2]  = '{4'h2, 9'h002, 1'b0, 1'b0};
        tbl[3]  = '{4'h3, 9'h004, 1'b0, 1'b0};
        tbl[4]  = '{4'h4, 9'h008, 1'b0, 1'b0};
        tbl[5]  = '{4'h5, 9'h010, 1'b0, 1'b0};
        tbl[6]  = '{4'h6, 9'h020, 1'b0, 1'b0};
        tbl[7]  = '{4'h7, 9'h040, 1'b0, 1'b0};
        tbl[8]  = '{4'h8, 9'h080, 1'b0, 1'b0};
        tbl[9]  = '{4'h9, 9'h100, 1'b0, 1'b0};
        tbl[10] = '{4'hA, 9'h000, 1'b0, 1'b1};
        tbl[11] = '{4'hB, 9'h000, 1'b0, 1'b1};
        tbl[12] = '{4'hC, 9'h000, 1'b0, 1'b1};
        tbl[13] = '{4'hD, 9'h000, 1'b0, 1'b1};
        tbl[14] = '{4'hE, 9'h000, 1'b0, 1'b1};
        tbl[15] = '{4'hF, 9'h000, 1'b0, 1'b1};

        // Reset held with a nonzero code on the inputs.
        {a0, a1, a2, a3} = 4'h5;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        check("rst_s0_outs",  {b0, z0, e0, c0}, 12'h000);
        check("rst_pol_outs", {bl, zl, el, cl}, {9'h1ff, 1'b1, 2'b00});

        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rel_b5",  b0, 9'h010);
        check("rel_chg", c0, 1'b1);
        tick();
        check("rel_chg_clear", c0, 1'b0);

        // Hold steady: a single chg pulse for the 5->4 step.
        set_code(4'h4);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(c0);
        end
        check("hold_b4",     b0, 9'h008);
        check("hold_pulses", pulses, 1);

        // Latency through two sync stages: b7 rises on the third edge.
        set_code(4'h3);
        repeat (5) tick();
        set_code(4'h7);
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e < 3) check($sformatf("lat_edge%0d_b3", e), b2s, 9'h004);
            else       check("lat_edge3_b7", b2s, 9'h040);
        end

        // Asynchronous reset between edges.
        set_code(4'h9);
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        check("arst_b_drop",   b0, 9'h000);
        check("arst_pol_high", bl, 9'h1ff);
        #1 rst_n = 1'b1;
        tick();
        check("arst_rel_b9",  b0, 9'h100);
        check("arst_rel_chg", c0, 1'b1);

        // Active-low polarity.
        set_code(4'h2);
        tick();
        check("pol2_b",    bl, 9'h1fd);
        check("pol2_zero", zl, 1'b1);
        check("pol2_err",  el, 1'b0);
        set_code(4'hC);
        tick();
        check("polC_b",    bl, 9'h1ff);
        check("polC_zero", zl, 1'b1);
        check("polC_err",  el, 1'b1);

        // Full sweep 0..15, each code held five clocks.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            set_code(tbl[i].code);
            tick();
            check($sformatf("sweep%0d_b", i),    b0, tbl[i].b);
            check($sformatf("sweep%0d_zero", i), z0, tbl[i].zero);
            check($sformatf("sweep%0d_err", i),  e0, tbl[i].err);
            check($sformatf("sweep%0d_chg", i),  c0, 1'b1);
            pulses += int'(c0);
            for (int j = 0; j < 4; j++) begin
                tick();
                pulses += int'(c0);
            end
        end
        check("sweep_pulses", pulses, 16);

        // Random codes with occasional resets; the model checker compares.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(39) == 0) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                repeat ($urandom_range(2, 1)) @(posedge clk);
                #3 rst_n = 1'b1;
            end else if ($urandom_range(2) != 0) begin
                set_code(4'($urandom_range(15)));
            end else begin
                @(posedge clk);
            end
        end
        repeat (4) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
